// File: rtl/rat_input_pkg.sv
// Shared types and defaults for the RAT board input-conditioning blocks.
package rat_input_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_CHK   = 2'd1,
        HELD        = 2'd2,
        RELEASE_CHK = 2'd3
    } btn_state_t;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 32'd500000;
    localparam int unsigned REPEAT_CYCLES_DEF   = 32'd25000000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; async active-low reset to 0.
module sync_2ff #(
    parameter int unsigned WIDTH = 32'd1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1_r;
    logic [WIDTH-1:0] s2_r;

    // metastability chain: only the second stage is consumed downstream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r <= '0;
            s2_r <= '0;
        end else begin
            s1_r <= d;
            s2_r <= s1_r;
        end
    end

    assign q = s2_r;

endmodule

// File: rtl/btn_debounce_pulse.sv
// Button debouncer producing one clean pulse per accepted press plus a debounced level.
// Optional feature macro AUTO_REPEAT_EN: periodic repeat pulses while the button is held.
module btn_debounce_pulse
    import rat_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       BTN_RAW,
    output logic       BTN_PULSE,
    output logic       BTN_LEVEL,
    output logic [7:0] PRESS_CNT
);

    localparam int unsigned CNT_W = $clog2(max_u(DEBOUNCE_CYCLES, REPEAT_CYCLES) + 32'd1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
`ifdef AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 32'd1);
`endif

    logic             btn_sync_s;
    btn_state_t       state_r;
    btn_state_t       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             pulse_r;
    logic             pulse_nxt_s;
    logic             level_r;
    logic             level_nxt_s;
    logic [7:0]       press_cnt_r;
    logic [7:0]       press_cnt_nxt_s;

    sync_2ff #(.WIDTH(32'd1)) u_sync (
        .clk   (CLK),
        .rst_n (RST_N),
        .d     (BTN_RAW),
        .q     (btn_sync_s)
    );

    // state, counter and all outputs are registered together
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            pulse_r     <= 1'b0;
            level_r     <= 1'b0;
            press_cnt_r <= 8'd0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            pulse_r     <= pulse_nxt_s;
            level_r     <= level_nxt_s;
            press_cnt_r <= press_cnt_nxt_s;
        end
    end

    // next-state logic; the counter is cleared on every state change
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        pulse_nxt_s     = 1'b0;
        level_nxt_s     = level_r;
        press_cnt_nxt_s = press_cnt_r;
        case (state_r)
            IDLE: begin
                cnt_nxt_s = '0;
                if (btn_sync_s) begin
                    state_nxt_s = PRESS_CHK;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PRESS_CHK: begin
                if (!btn_sync_s) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = '0;
                end else if (cnt_r == DEB_LAST) begin
                    state_nxt_s     = HELD;
                    cnt_nxt_s       = '0;
                    pulse_nxt_s     = 1'b1;
                    level_nxt_s     = 1'b1;
                    press_cnt_nxt_s = press_cnt_r + 8'd1;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            HELD: begin
                if (!btn_sync_s) begin
                    state_nxt_s = RELEASE_CHK;
                    cnt_nxt_s   = '0;
`ifdef AUTO_REPEAT_EN
                end else if (cnt_r == REP_LAST) begin
                    cnt_nxt_s   = '0;
                    pulse_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
`else
                end else begin
                    cnt_nxt_s = '0;
                end
`endif
            end
            RELEASE_CHK: begin
                // a high sample here is release bounce: back to HELD silently
                if (btn_sync_s) begin
                    state_nxt_s = HELD;
                    cnt_nxt_s   = '0;
                end else if (cnt_r == DEB_LAST) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = '0;
                    level_nxt_s = 1'b0;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = '0;
                level_nxt_s = 1'b0;
            end
        endcase
    end

    assign BTN_PULSE = pulse_r;
    assign BTN_LEVEL = level_r;
    assign PRESS_CNT = press_cnt_r;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Self-checking bench for btn_debounce_pulse: run-length reference model plus directed scenarios.
module tb_btn_debounce_pulse;

    localparam int unsigned D = 4;
    localparam int unsigned R = 8;

    logic       CLK;
    logic       RST_N;
    logic       BTN_RAW;
    logic       BTN_PULSE;
    logic       BTN_LEVEL;
    logic [7:0] PRESS_CNT;

    int unsigned chk_cnt  = 0;
    int unsigned pass_cnt = 0;

    btn_debounce_pulse #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .BTN_RAW   (BTN_RAW),
        .BTN_PULSE (BTN_PULSE),
        .BTN_LEVEL (BTN_LEVEL),
        .PRESS_CNT (PRESS_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: run lengths of the two-cycle-delayed button samples.
    logic        m_s1, m_s2, m_lvl, m_pulse;
    logic [7:0]  m_cnt;
    int unsigned m_run1, m_run0, m_hold;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_s1 <= 1'b0; m_s2 <= 1'b0; m_lvl <= 1'b0; m_pulse <= 1'b0;
            m_cnt <= 8'd0; m_run1 <= 0; m_run0 <= 0; m_hold <= 0;
        end else begin : step
            int unsigned r1, r0, h;
            logic lv, pu;
            logic [7:0] c;
            r1 = m_run1; r0 = m_run0; h = m_hold; lv = m_lvl; c = m_cnt; pu = 1'b0;
            if (!lv) begin
                r0 = 0;
                if (m_s2) begin
                    r1 = r1 + 1;
                    if (r1 == D + 1) begin
                        lv = 1'b1; pu = 1'b1; c = c + 8'd1; r1 = 0; h = 0;
                    end
                end else begin
                    r1 = 0;
                end
            end else begin
                r1 = 0;
                if (m_s2) begin
                    if (r0 > 0) begin
                        r0 = 0; h = 0;
                    end else begin
`ifdef AUTO_REPEAT_EN
                        h = h + 1;
                        if (h == R) begin
                            pu = 1'b1; h = 0;
                        end
`endif
                    end
                end else begin
                    h = 0;
                    r0 = r0 + 1;
                    if (r0 == D + 1) begin
                        lv = 1'b0; r0 = 0;
                    end
                end
            end
            m_run1 <= r1; m_run0 <= r0; m_hold <= h; m_lvl <= lv; m_cnt <= c; m_pulse <= pu;
            m_s2 <= m_s1;
            m_s1 <= BTN_RAW;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        chk("pulse_vs_model", {31'd0, BTN_PULSE}, {31'd0, m_pulse});
        chk("level_vs_model", {31'd0, BTN_LEVEL}, {31'd0, m_lvl});
        chk("cnt_vs_model", {24'd0, PRESS_CNT}, {24'd0, m_cnt});
    end

    int first_dut, first_mdl, npulse;

    // Run n edges, recording the edge index of the first pulse and the pulse count.
    task automatic run_edges(input int n);
        first_dut = -1; first_mdl = -1; npulse = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge CLK); #1;
            if (BTN_PULSE) begin
                npulse++;
                if (first_dut < 0) first_dut = i;
            end
            if (m_pulse && first_mdl < 0) first_mdl = i;
        end
    endtask

    task automatic set_raw(input logic v);
        @(negedge CLK);
        BTN_RAW = v;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N = 1'b0;
        BTN_RAW = 1'b0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
    endtask

    initial begin
        int prob;
        RST_N = 1'b0;
        BTN_RAW = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        chk("reset_pulse", {31'd0, BTN_PULSE}, 32'd0);
        chk("reset_level", {31'd0, BTN_LEVEL}, 32'd0);
        chk("reset_cnt", {24'd0, PRESS_CNT}, 32'd0);

        // clean press held 20 cycles
        set_raw(1'b1);
        run_edges(20);
        chk("clean_first_edge", first_dut, 32'd6);
        chk("model_first_edge", first_mdl, 32'd6);
`ifdef AUTO_REPEAT_EN
        chk("clean_npulse", npulse, 32'd2);
`else
        chk("clean_npulse", npulse, 32'd1);
`endif
        chk("clean_level", {31'd0, BTN_LEVEL}, 32'd1);
        chk("clean_cnt", {24'd0, PRESS_CNT}, 32'd1);

        // release bounce: 2 low then 10 high
        set_raw(1'b0);
        run_edges(2);
        set_raw(1'b1);
        run_edges(10);
`ifndef AUTO_REPEAT_EN
        chk("relbounce_npulse", npulse, 32'd0);
`endif
        chk("relbounce_level", {31'd0, BTN_LEVEL}, 32'd1);
        chk("relbounce_cnt", {24'd0, PRESS_CNT}, 32'd1);
        set_raw(1'b0);
        run_edges(12);
        chk("release_level", {31'd0, BTN_LEVEL}, 32'd0);

        // press bounce: toggle every cycle for 8 cycles
        npulse = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            BTN_RAW = (i % 2 == 0);
            @(posedge CLK); #1;
            if (BTN_PULSE) npulse++;
        end
        begin : bounce_tail
            int np;
            np = npulse;
            set_raw(1'b0);
            run_edges(12);
            chk("bounce_npulse", np + npulse, 32'd0);
        end
        chk("bounce_cnt", {24'd0, PRESS_CNT}, 32'd1);
        chk("bounce_level", {31'd0, BTN_LEVEL}, 32'd0);

        // three spaced presses from reset, then 256 more to wrap
        do_reset();
        begin : three
            int tot;
            tot = 0;
            for (int k = 0; k < 3; k++) begin
                set_raw(1'b1); run_edges(10); tot += npulse;
                set_raw(1'b0); run_edges(30); tot += npulse;
            end
            chk("three_npulse", tot, 32'd3);
        end
        chk("three_cnt", {24'd0, PRESS_CNT}, 32'd3);
        for (int k = 0; k < 256; k++) begin
            set_raw(1'b1); run_edges(10);
            set_raw(1'b0); run_edges(12);
        end
        chk("wrap_cnt", {24'd0, PRESS_CNT}, 32'd3);

        // async reset in the middle of press qualification
        set_raw(1'b1);
        run_edges(4);
        #3;
        RST_N = 1'b0;
        #1;
        chk("async_pulse", {31'd0, BTN_PULSE}, 32'd0);
        chk("async_level", {31'd0, BTN_LEVEL}, 32'd0);
        chk("async_cnt", {24'd0, PRESS_CNT}, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        run_edges(20);
        chk("rst_held_first_edge", first_dut, 32'd6);
        chk("rst_held_cnt", {24'd0, PRESS_CNT}, 32'd1);

        // long hold: repeat pulses only with the auto-repeat build
        do_reset();
        set_raw(1'b1);
        run_edges(36);
        begin : hold
            int np;
            np = npulse;
            set_raw(1'b0);
            run_edges(12);
`ifdef AUTO_REPEAT_EN
            chk("hold_npulse", np + npulse, 32'd4);
`else
            chk("hold_npulse", np + npulse, 32'd1);
`endif
        end
        chk("hold_cnt", {24'd0, PRESS_CNT}, 32'd1);

        // randomized bouncing input with varying toggle probability
        for (int blk = 0; blk < 30; blk++) begin
            prob = $urandom_range(2, 60);
            for (int i = 0; i < 100; i++) begin
                @(negedge CLK);
                if ($urandom_range(0, 99) < prob) BTN_RAW = ~BTN_RAW;
            end
        end
        set_raw(1'b0);
        repeat (12) @(posedge CLK);
        @(negedge CLK);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
